// File: rtl/accelerator_read_strengths_buffered_if.sv
// rtl/accelerator_read_strengths_buffered_if.sv - run control, strength input and buffered output signals
interface accelerator_read_strengths_buffered_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 ERROR;
    logic                 BETA_IN_ENABLE;
    logic                 OUT_HOLD;
    logic                 BETA_OUT_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_R_IN;
    logic [DATA_SIZE-1:0] BETA_IN;
    logic [DATA_SIZE-1:0] BETA_OUT;

    modport slave (
        input  START, BETA_IN_ENABLE, OUT_HOLD, SIZE_R_IN, BETA_IN,
        output READY, ERROR, BETA_OUT_ENABLE, BETA_OUT
    );

    modport master (
        output START, BETA_IN_ENABLE, OUT_HOLD, SIZE_R_IN, BETA_IN,
        input  READY, ERROR, BETA_OUT_ENABLE, BETA_OUT
    );
endinterface

// File: rtl/accelerator_read_strengths_buffered.sv
// rtl/accelerator_read_strengths_buffered.sv - oneplus read strengths, buffered per run and drained in order
module accelerator_read_strengths_buffered #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRAC_BITS    = 32,
    parameter int HEADS_MAX    = 8
) (
    input  logic CLK,
    input  logic RST,
    accelerator_read_strengths_buffered_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam int EXT_W  = DATA_SIZE + 2;
    localparam int ADDR_W = (HEADS_MAX > 1) ? $clog2(HEADS_MAX) : 1;

    localparam logic signed [EXT_W-1:0] C_ONE = (EXT_W'(1)) << FRAC_BITS;
    localparam logic signed [EXT_W-1:0] C_MAX = {3'b000, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] C_LN2 =
        EXT_W'(longint'(0.693147 * (2.0 ** FRAC_BITS)));
    localparam logic [DATA_SIZE-1:0] C_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    state_t r_state;
    state_t w_next;

    logic                    r_ready;
    logic                    r_error;
    logic                    r_bad;
    logic                    r_out_en;
    logic [DATA_SIZE-1:0]    r_out;
    logic                    r_in_valid;
    logic [DATA_SIZE-1:0]    r_in_data;
    logic [CONTROL_SIZE-1:0] r_size;
    logic [CONTROL_SIZE-1:0] r_cap_cnt;
    logic [CONTROL_SIZE-1:0] r_wr_idx;
    logic [CONTROL_SIZE-1:0] r_rd_idx;
    logic [DATA_SIZE-1:0]    r_buf [HEADS_MAX];

    logic                    w_size_bad;
    logic                    w_capture;
    logic                    w_last_wr;
    logic                    w_last_rd;
    logic signed [EXT_W-1:0] w_x;
    logic signed [EXT_W-1:0] w_abs;
    logic signed [EXT_W-1:0] w_relu;
    logic signed [EXT_W-1:0] w_corr;
    logic signed [EXT_W-1:0] w_sum;
    logic [DATA_SIZE-1:0]    w_y;

    assign w_size_bad = (bus.SIZE_R_IN == '0) || (bus.SIZE_R_IN > DATA_SIZE'(HEADS_MAX));
    assign w_capture  = (r_state == S_LOAD) && bus.BETA_IN_ENABLE && (r_cap_cnt != r_size);
    assign w_last_wr  = r_in_valid && (r_wr_idx == r_size - CONTROL_SIZE'(1));
    assign w_last_rd  = !bus.OUT_HOLD && (r_rd_idx == r_size - CONTROL_SIZE'(1));

    // Two extra bits keep ONE + relu + corr exact before saturating
    always_comb begin
        w_x = EXT_W'(signed'(r_in_data));
        if (r_in_data == C_MIN) begin
            w_abs = C_MAX;
        end else if (w_x[EXT_W-1]) begin
            w_abs = -w_x;
        end else begin
            w_abs = w_x;
        end
        w_relu = w_x[EXT_W-1] ? '0 : w_x;
        w_corr = C_LN2 - (w_abs >>> 2);
        if (w_corr[EXT_W-1]) begin
            w_corr = '0;
        end
        w_sum = C_ONE + w_relu + w_corr;
        w_y   = (w_sum > C_MAX) ? C_MAX[DATA_SIZE-1:0] : w_sum[DATA_SIZE-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.START) w_next = w_size_bad ? S_DONE : S_LOAD;
            S_LOAD:  if (w_last_wr) w_next = S_DRAIN;
            S_DRAIN: if (w_last_rd) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_bad      <= 1'b0;
            r_out_en   <= 1'b0;
            r_out      <= '0;
            r_in_valid <= 1'b0;
            r_in_data  <= '0;
            r_size     <= '0;
            r_cap_cnt  <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
        end else begin
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_out_en   <= 1'b0;
            r_in_valid <= w_capture;
            if (w_capture) begin
                r_in_data <= bus.BETA_IN;
                r_cap_cnt <= r_cap_cnt + CONTROL_SIZE'(1);
            end
            if (r_in_valid) begin
                r_wr_idx <= r_wr_idx + CONTROL_SIZE'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_bad <= w_size_bad;
                        if (!w_size_bad) begin
                            r_size    <= CONTROL_SIZE'(bus.SIZE_R_IN);
                            r_cap_cnt <= '0;
                            r_wr_idx  <= '0;
                            r_rd_idx  <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!bus.OUT_HOLD) begin
                        r_out    <= r_buf[r_rd_idx[ADDR_W-1:0]];
                        r_out_en <= 1'b1;
                        r_rd_idx <= r_rd_idx + CONTROL_SIZE'(1);
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_error <= r_bad;
                end
                default: ;
            endcase
        end
    end

    // Buffer holds no reset; stale entries are unreachable because the indices restart each run
    always_ff @(posedge CLK) begin
        if (!RST && r_in_valid) begin
            r_buf[r_wr_idx[ADDR_W-1:0]] <= w_y;
        end
    end

    assign bus.READY           = r_ready;
    assign bus.ERROR           = r_error;
    assign bus.BETA_OUT_ENABLE = r_out_en;
    assign bus.BETA_OUT        = r_out;
endmodule

// File: tb/tb_accelerator_read_strengths_buffered.sv
// tb/tb_accelerator_read_strengths_buffered.sv - table and scoreboard bench for accelerator_read_strengths_buffered
module tb_accelerator_read_strengths_buffered;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    accelerator_read_strengths_buffered_if #(.DATA_SIZE(DW)) bus();

    accelerator_read_strengths_buffered #(
        .DATA_SIZE(DW), .CONTROL_SIZE(32), .FRAC_BITS(16), .HEADS_MAX(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_cnt = 0;
    int          first_cyc = -1;
    logic        last_err = 1'b0;
    logic        hold_q = 1'b0;
    logic [31:0] last_out = '0;

    function automatic logic [31:0] model(input logic [31:0] x);
        longint xs, a, relu, corr, y;
        xs = longint'(signed'(x));
        if (xs == -64'sd2147483648) a = 2147483647;
        else if (xs < 0) a = -xs;
        else a = xs;
        relu = (xs > 0) ? xs : 0;
        corr = 45426 - (a / 4);
        if (corr < 0) corr = 0;
        y = 65536 + relu + corr;
        if (y > 2147483647) y = 2147483647;
        return y[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        hold_q <= bus.OUT_HOLD;
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.BETA_OUT_ENABLE) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("out_during_hold", {31'd0, hold_q}, 32'd0);
                check("beta_out_sign", {31'd0, bus.BETA_OUT[31]}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_out", bus.BETA_OUT, 32'hx);
                end else begin
                    check("beta_out", bus.BETA_OUT, sb.pop_front());
                end
                last_out = bus.BETA_OUT;
            end else begin
                check("beta_out_holds", bus.BETA_OUT, last_out);
            end
            if (bus.READY) begin
                ready_cnt++;
                last_err = bus.ERROR;
            end
        end else begin
            last_out = '0;
        end
    end

    task automatic run(input int r, input int row0, input bit rnd,
                       input int hold_after, input int hold_len);
        int          t_last, seen, budget, rc0;
        bit          held, done;
        logic [31:0] x, y;
        rc0       = ready_cnt;
        first_cyc = -1;
        bus.START     = 1'b1;
        bus.SIZE_R_IN = r;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < r; i++) begin
            if (rnd) begin
                x = $urandom;
                y = model(x);
            end else begin
                x = tbl[row0 + i].x;
                y = tbl[row0 + i].y;
            end
            sb.push_back(y);
            bus.BETA_IN_ENABLE = 1'b1;
            bus.BETA_IN        = x;
            tick();
        end
        bus.BETA_IN_ENABLE = 1'b0;
        bus.BETA_IN        = 32'hDEAD_BEEF;
        t_last = cyc;
        seen = 0; held = 0; done = 0; budget = 0;
        while (!done && budget < 200) begin
            @(negedge CLK);
            budget++;
            if (bus.BETA_OUT_ENABLE) seen++;
            if (bus.READY) done = 1;
            if (hold_len > 0 && !held && seen == hold_after) begin
                held = 1;
                bus.OUT_HOLD = 1'b1;
                repeat (hold_len) @(posedge CLK);
                #1 bus.OUT_HOLD = 1'b0;
            end
        end
        check("ready_seen", {31'd0, done}, 32'd1);
        repeat (3) tick();
        check("ready_once", ready_cnt - rc0, 32'd1);
        check("error_clear", {31'd0, last_err}, 32'd0);
        check("out_count", seen, r);
        check("sb_drained", sb.size(), 32'd0);
        check("first_latency", first_cyc - t_last, 32'd2);
        sb.delete();
    endtask

    task automatic bad_size(input int sz);
        int rc0;
        rc0 = ready_cnt;
        bus.START     = 1'b1;
        bus.SIZE_R_IN = sz;
        tick();
        bus.START = 1'b0;
        @(negedge CLK);
        check("bad_ready_early", {31'd0, bus.READY}, 32'd0);
        @(negedge CLK);
        check("bad_ready", {31'd0, bus.READY}, 32'd1);
        check("bad_error", {31'd0, bus.ERROR}, 32'd1);
        repeat (3) tick();
        check("bad_ready_once", ready_cnt - rc0, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {31'd0, bus.READY}, 32'd0);
        check("rst_error", {31'd0, bus.ERROR}, 32'd0);
        check("rst_out_en", {31'd0, bus.BETA_OUT_ENABLE}, 32'd0);
        check("rst_beta_out", bus.BETA_OUT, 32'd0);
    endtask

    initial begin
        int rc0;
        tbl[0] = '{32'd0,          32'd110962};
        tbl[1] = '{32'd65536,      32'd160114};
        tbl[2] = '{-32'sd262144,   32'd65536};
        tbl[3] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF};
        tbl[4] = '{32'h8000_0000,  32'd65536};
        tbl[5] = '{32'd131072,     32'd209266};
        tbl[6] = '{-32'sd65536,    32'd94578};
        tbl[7] = '{32'd4,          32'd110965};

        bus.START = 1'b0; bus.SIZE_R_IN = '0; bus.BETA_IN_ENABLE = 1'b0;
        bus.BETA_IN = '0; bus.OUT_HOLD = 1'b0;
        RST = 1'b1;
        repeat (3) tick();
        check_reset_outputs();
        RST = 1'b0;
        tick();

        run(3, 0, 1'b0, 0, 0);
        run(2, 3, 1'b0, 0, 0);
        run(8, 0, 1'b0, 2, 3);
        run(5, 0, 1'b1, 0, 0);
        bad_size(0);
        bad_size(9);

        bus.START = 1'b1; bus.SIZE_R_IN = 4;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.BETA_IN_ENABLE = 1'b1;
            bus.BETA_IN        = tbl[5 + i].x;
            tick();
        end
        rc0 = ready_cnt;
        RST = 1'b1; bus.START = 1'b1; bus.SIZE_R_IN = 0;
        bus.BETA_IN_ENABLE = 1'b1; bus.BETA_IN = 32'h1234_5678;
        tick();
        RST = 1'b0; bus.START = 1'b0; bus.BETA_IN_ENABLE = 1'b0;
        sb.delete();
        @(negedge CLK);
        check_reset_outputs();
        repeat (5) tick();
        check("rst_start_ignored", ready_cnt - rc0, 32'd0);
        run(1, 0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accelerator_read_strengths_buffered.md
ACCELERATOR_READ_STRENGTHS_BUFFERED -- requirements
Module: accelerator_read_strengths_buffered

Interface
REQ-001 Parameter DATA_SIZE, default 64: width of every data word; signed two's complement, fixed point.
REQ-002 Parameter CONTROL_SIZE, default 64: width of the size/count path.
REQ-003 Parameter FRAC_BITS, default 32: fractional bits of the fixed-point format; ONE = 2^FRAC_BITS.
REQ-004 Parameter HEADS_MAX, default 8: maximum read heads R; depth of the result buffer.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 START  input  1  begin a run; sampled only in IDLE.
REQ-008 READY  output  1  one-cycle pulse at end of run, normal or error.
REQ-009 ERROR  output  1  valid with READY; 1 = run rejected for a bad SIZE_R_IN.
REQ-010 BETA_IN_ENABLE  input  1  BETA_IN valid this cycle.
REQ-011 OUT_HOLD  input  1  stalls output drain while high.
REQ-012 BETA_OUT_ENABLE  output  1  BETA_OUT valid this cycle.
REQ-013 SIZE_R_IN  input  DATA_SIZE  head count R; sampled with START.
REQ-014 BETA_IN  input  DATA_SIZE  raw strength beta^(t;i).
REQ-015 BETA_OUT  output  DATA_SIZE  beta(t;i) = oneplus(beta^(t;i)), in input order.

Function
REQ-016 States: IDLE, LOAD, DRAIN, DONE.
REQ-017 IDLE: on START with 1 <= SIZE_R_IN <= HEADS_MAX, latch R and clear the index; go to LOAD.
REQ-018 IDLE: on START with SIZE_R_IN = 0 or SIZE_R_IN > HEADS_MAX, go to DONE with ERROR = 1; no data is processed.
REQ-019 START outside IDLE is ignored.
REQ-020 LOAD: each BETA_IN_ENABLE cycle captures one word. The oneplus result is registered one cycle later into buffer[index]. BETA_IN_ENABLE outside LOAD is ignored.
REQ-021 LOAD -> DRAIN in the cycle after the R-th result is written into the buffer.
REQ-022 With OUT_HOLD low, the first BETA_OUT_ENABLE is exactly 2 cycles after the cycle that captured the R-th input.
REQ-023 DRAIN: for each cycle with OUT_HOLD low, assert BETA_OUT_ENABLE for one cycle with buffer[k], k = 0..R-1 in order. While OUT_HOLD is high, BETA_OUT_ENABLE = 0 and k holds.
REQ-024 DRAIN -> DONE in the cycle after output R-1 is presented. DONE asserts READY for one cycle, then returns to IDLE. ERROR is cleared on the IDLE entry.
REQ-025 oneplus arithmetic, in full precision before saturation:
- a = |x|, with the most negative value mapped to the maximum positive value;
- relu = max(x, 0);
- corr = max(LN2 - (a >> 2), 0), where LN2 = round(0.693147 * 2^FRAC_BITS);
- y = ONE + relu + corr, saturated to the maximum positive DATA_SIZE value.
REQ-026 BETA_OUT is never negative.
REQ-027 BETA_OUT holds its last value while BETA_OUT_ENABLE is low.

Reset
REQ-028 RST high at any edge, including mid-LOAD or mid-DRAIN:
- state becomes IDLE;
- READY, ERROR, BETA_OUT_ENABLE and BETA_OUT become 0;
- index, count and stored R are cleared;
- buffer contents are don't-care and never emitted.
REQ-029 START or BETA_IN_ENABLE asserted in the same cycle as RST has no effect.

Verification
REQ-030 The bench uses DATA_SIZE=32, FRAC_BITS=16, HEADS_MAX=8 (ONE=65536, LN2=45426).
REQ-031 Basic values: R=3, inputs 0, 65536, -262144 -> BETA_OUT 110962, 160114, 65536 in order. READY pulses once with ERROR=0.
REQ-032 Saturation and extremes: R=2, inputs 0x7FFFFFFF, 0x80000000 -> outputs 0x7FFFFFFF, 65536.
REQ-033 Bad size:
- SIZE_R_IN=0 -> READY=1, ERROR=1 on the second cycle after START; no BETA_OUT_ENABLE;
- same for SIZE_R_IN=9.
REQ-034 Timing and stall: R=8, inputs back-to-back, OUT_HOLD high for 3 cycles after the 2nd output -> first output exactly 2 cycles after the last input, 8 outputs in order, no output during hold, READY once.
REQ-035 Reset mid-run: RST after 2 of 4 inputs, then a fresh START with R=1 and input 0 -> single output 110962; no stale data emitted.
